approx_mult_seq_ctrl: RTL
=========================

Name: approx_mult_seq_ctrl

Overview:
- Sequencing controller that drives one external combinational 4x2 approximate multiplier core.
- Computes a 4 x B_WIDTH product by feeding 2-bit slices of B to the core, LSB slice first.
- Accumulates each shifted partial product into a result register.
- Valid/ready handshake on input and output; sits between an operand producer and a result consumer in the approximate-arithmetic datapath.

Parameters:
- B_WIDTH, 8: width of operand B; must be even and >= 2; slice count N = B_WIDTH/2.
- R_WIDTH, B_WIDTH+4: result and accumulator width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  operands valid.
- in_ready_o  output  1  controller can accept operands.
- a_i  input  4  multiplicand.
- b_i  input  B_WIDTH  multiplier.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- result_o  output  R_WIDTH  accumulated product.
- busy_o  output  1  high in RUN or DONE.
- mul_a_o  output  4  to core a_i.
- mul_b_o  output  2  to core b_i (current slice).
- mul_prod_i  input  6  from core prod_o; combinational, same cycle.

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; slice counter, accumulator, a/b holding registers cleared; in_ready_o=1; out_valid_o=0; busy_o=0; result_o=0; mul_a_o=0; mul_b_o=0. Asserting reset mid-operation aborts the operation and discards it, with no output.
- States:
  - IDLE: in_ready_o=1. On in_valid_i && in_ready_o, latch a_i and b_i, clear the accumulator and counter k=0, then go to RUN.
  - RUN: in_ready_o=0. Drive mul_a_o=a_reg and mul_b_o=b_reg[2k+1:2k].
    - Each cycle: acc <= acc + (zero-extend(mul_prod_i) << 2k); k increments.
    - After the slice k=N-1 is accumulated, go to DONE.
  - DONE: out_valid_o=1 and result_o=acc, held stable until out_ready_i=1. On handshake, go to IDLE and drop out_valid_o.
- Core drive outside RUN: mul_a_o and mul_b_o are 0 in IDLE and DONE (suppresses core toggling).
- Latency: input handshake at edge t; RUN occupies cycles t+1..t+N; out_valid_o is high from cycle t+N+1. For B_WIDTH=8 that is 4 RUN cycles, with the result visible on the 5th cycle.
- Throughput: one operation per N+2 cycles minimum. There is no input/output overlap: in_ready_o=0 in DONE even when out_ready_i=1.
- Arithmetic:
  - Accumulation is unsigned, mod 2^R_WIDTH. At the default widths no overflow is possible: 6-bit product << 2(N-1) stays within R_WIDTH.
  - The controller never corrects core approximation error; result_o equals the sum of the shifted core outputs.
- in_valid_i while not in IDLE is ignored; the operands are not latched.
- out_ready_i outside DONE is ignored.
- b_i=0 or a_i=0: still runs all N slices (unless the optional feature is enabled) and produces 0 with an exact core.

Optional Feature:
- Macro: APPROX_MULT_SKIP_ZERO_EN.
- Defined: in RUN, when the remaining unprocessed bits b_reg[B_WIDTH-1:2k] are all zero, go directly to DONE without accumulating that slice.
  - b_i=0 spends zero RUN cycles: out_valid_o is high at cycle t+1.
  - Latency becomes 1 + (index of highest nonzero slice + 1) cycles.
- Undefined: fixed N RUN cycles, exactly as in Behaviour.

Test Plan:
1. Exact core model on the bench (mul_prod_i=mul_a_o*mul_b_o); a_i=9, b_i=0xB6 -> mul_b_o sequence 2,1,3,2 over 4 RUN cycles; result_o=1638 (0x666); out_valid_o rises 5 cycles after the handshake.
2. Bench core modelling the approximate truth table (prod[0] forced 0); a_i=15, b_i=0xFF -> result_o equals the sum over k of core(15,3)<<2k, compared against the bench model; a_i=15, b_i=0x00 -> 0.
3. Backpressure: out_ready_i=0 for 10 cycles after out_valid_o -> result_o stable, in_ready_o=0; then out_ready_i=1 -> IDLE next cycle, in_ready_o=1.
4. Reset mid-RUN: rst_ni low at RUN cycle 2 (asynchronously, between edges) -> all outputs at reset values immediately; no out_valid_o afterwards; next operand pair (a=3, b=0x04) gives 12.
5. in_valid_i held high during RUN/DONE with changing a_i/b_i -> result unaffected; back-to-back ops a=1,b=0x01 then a=2,b=0x02 -> results 1 then 4, spacing N+2 cycles.
6. APPROX_MULT_SKIP_ZERO_EN defined: b_i=0x00 -> out_valid_o at t+1, result 0; b_i=0x03, a_i=5 -> 1 RUN cycle, result 15; b_i=0x80 -> 4 RUN cycles.

Source files
------------

// File: rtl/approx_mult_seq_ctrl.sv
// approx_mult_seq_ctrl: sequences one external combinational 4x2 approximate
// multiplier core to form a 4 x B_WIDTH product, two bits of B per cycle,
// LSB slice first, accumulating the shifted partial products.
//
// Ports:
//   clk_i, rst_ni             clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o     operand handshake; a_i (4b), b_i (B_WIDTH b)
//   out_valid_o/out_ready_i   result handshake; result_o (R_WIDTH b)
//   busy_o                    high while an operation is in RUN or DONE
//   mul_a_o, mul_b_o          operands to the core (zero outside RUN)
//   mul_prod_i                core product, combinational in the same cycle
//
// Optional feature: define APPROX_MULT_SKIP_ZERO_EN to finish early once the
// unprocessed upper bits of B are all zero (B == 0 spends no RUN cycles).
module approx_mult_seq_ctrl #(
    parameter int unsigned B_WIDTH = 8,
    parameter int unsigned R_WIDTH = B_WIDTH + 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [3:0]         a_i,
    input  logic [B_WIDTH-1:0] b_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [R_WIDTH-1:0] result_o,
    output logic               busy_o,
    output logic [3:0]         mul_a_o,
    output logic [1:0]         mul_b_o,
    input  logic [5:0]         mul_prod_i
);

    localparam int unsigned N   = B_WIDTH / 2;
    localparam int unsigned K_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state_q,     state_d;
    logic [K_W-1:0]     k_q,         k_d;
    logic [R_WIDTH-1:0] acc_q,       acc_d;
    logic [B_WIDTH-1:0] b_rem_q,     b_rem_d;   // bits of B above the slice on the core
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;
    logic [3:0]         mul_a_q,     mul_a_d;   // also serves as the A holding register
    logic [1:0]         mul_b_q,     mul_b_d;

    logic [R_WIDTH-1:0] acc_sum;
    logic               last_slice;

    // Partial product of the slice currently on the core, weighted by 4^k.
    assign acc_sum = acc_q + (R_WIDTH'(mul_prod_i) << {k_q, 1'b0});

`ifdef APPROX_MULT_SKIP_ZERO_EN
    // Stop as soon as nothing nonzero remains above the current slice.
    assign last_slice = (k_q == K_W'(N - 1)) || (b_rem_q == '0);
`else
    assign last_slice = (k_q == K_W'(N - 1));
`endif

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            b_rem_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            b_rem_q     <= b_rem_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        b_rem_d     = b_rem_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    k_d        = '0;
                    acc_d      = '0;
                    b_rem_d    = b_i >> 2;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
`ifdef APPROX_MULT_SKIP_ZERO_EN
                    if (b_i == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        mul_a_d = a_i;
                        mul_b_d = b_i[1:0];
                    end
`else
                    state_d = RUN;
                    mul_a_d = a_i;
                    mul_b_d = b_i[1:0];
`endif
                end
            end

            RUN: begin
                acc_d = acc_sum;
                k_d   = k_q + K_W'(1);
                if (last_slice) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    mul_a_d     = '0;
                    mul_b_d     = '0;
                end else begin
                    mul_b_d = b_rem_q[1:0];
                    b_rem_d = b_rem_q >> 2;
                end
            end

            DONE: begin
                if (out_ready_i) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
                mul_a_d     = '0;
                mul_b_d     = '0;
            end
        endcase
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign result_o    = acc_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;

endmodule
